// File: rtl/framebuffer_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : framebuffer_fetch_pkg
// Brief   : State encoding, width derivation and RAM address composition
//           shared by the multi-subpanel framebuffer fetcher.
// Revision: 1.0  initial release
// ============================================================================
package framebuffer_fetch_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FETCH  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_FETCH  = c_ST_FETCH,
        ST_COMMIT = c_ST_COMMIT
    } fetch_state_t;

    function automatic int fb_sub_bits(input int num_subpanels);
        return (num_subpanels < 2) ? 1 : $clog2(num_subpanels);
    endfunction

    function automatic int fb_addr_width(input int num_subpanels, input int row_bits,
                                         input int column_bits);
        return fb_sub_bits(num_subpanels) + row_bits + column_bits;
    endfunction

    // Result is {sub, row, col_eff} right-aligned in 32 bits; callers keep the low ADDR_WIDTH bits.
    function automatic logic [31:0] fb_compose_addr(input logic [31:0] sub,
                                                    input logic [31:0] row,
                                                    input logic [31:0] col,
                                                    input logic        invert,
                                                    input int          row_bits,
                                                    input int          column_bits);
        logic [31:0] col_mask;
        logic [31:0] col_eff;
        col_mask = (32'd1 << column_bits) - 32'd1;
        col_eff  = (invert ? ~col : col) & col_mask;
        return (sub << (row_bits + column_bits)) | (row << column_bits) | col_eff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_fetch_multi_if.sv
`default_nettype none
// ============================================================================
// Module  : framebuffer_fetch_multi_if
// Brief   : Request/result bus and RAM read port of the framebuffer fetcher.
// Revision: 1.0  initial release
// ============================================================================
interface framebuffer_fetch_multi_if #(
    parameter int PIXEL_WIDTH   = 16,
    parameter int NUM_SUBPANELS = 2,
    parameter int COLUMN_BITS   = 6,
    parameter int ROW_BITS      = 4
);
    import framebuffer_fetch_pkg::*;

    localparam int c_addr_width = fb_addr_width(NUM_SUBPANELS, ROW_BITS, COLUMN_BITS);

    logic [COLUMN_BITS-1:0]               column_address;
    logic [ROW_BITS-1:0]                  row_address;
    logic                                 column_invert;
    logic                                 pixel_load_start;
    logic [PIXEL_WIDTH-1:0]               ram_data_in;
    logic [c_addr_width-1:0]              ram_address;
    logic                                 ram_clk_enable;
    logic                                 ram_reset;
    logic [NUM_SUBPANELS*PIXEL_WIDTH-1:0] pixel_data;
    logic                                 pixel_load_done;
    logic                                 busy;
    logic                                 start_overrun;

    modport master (
        output column_address, row_address, column_invert, pixel_load_start, ram_data_in,
        input  ram_address, ram_clk_enable, ram_reset, pixel_data, pixel_load_done,
               busy, start_overrun
    );

    modport slave (
        input  column_address, row_address, column_invert, pixel_load_start, ram_data_in,
        output ram_address, ram_clk_enable, ram_reset, pixel_data, pixel_load_done,
               busy, start_overrun
    );

endinterface
`default_nettype wire

// File: rtl/framebuffer_fetch_multi_fetch_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fetch_tag_pipe
// Brief   : LATENCY-deep {valid, sub index} delay line that marks when each
//           issued RAM read returns data.
// Revision: 1.0  initial release
// ============================================================================
module fetch_tag_pipe #(
    parameter int LATENCY  = 1,
    parameter int IDX_BITS = 1
) (
    input  wire logic                clk_in,
    input  wire logic                reset,
    input  wire logic                i_valid,
    input  wire logic [IDX_BITS-1:0] i_idx,
    output logic                     o_valid,
    output logic [IDX_BITS-1:0]      o_idx
);

    logic [IDX_BITS:0] r_stage [LATENCY];

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {i_valid, i_idx};
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign {o_valid, o_idx} = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/framebuffer_fetch_multi.sv
`default_nettype none
// ============================================================================
// Module  : framebuffer_fetch_multi
// Brief   : Fetches one pixel per subpanel from the framebuffer RAM and
//           publishes all of them atomically with a one-cycle done pulse.
// Revision: 1.0  initial release
// ============================================================================
module framebuffer_fetch_multi
    import framebuffer_fetch_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 16,
    parameter int NUM_SUBPANELS = 2,
    parameter int COLUMN_BITS   = 6,
    parameter int ROW_BITS      = 4,
    parameter int RAM_LATENCY   = 1
) (
    input  wire logic                 clk_in,
    input  wire logic                 reset,
    framebuffer_fetch_multi_if.slave  bus
);

    localparam int c_sub_bits   = fb_sub_bits(NUM_SUBPANELS);
    localparam int c_addr_width = fb_addr_width(NUM_SUBPANELS, ROW_BITS, COLUMN_BITS);
    localparam int c_cnt_bits   = c_sub_bits + 1;
    localparam logic [c_cnt_bits-1:0] c_num_subs = c_cnt_bits'(NUM_SUBPANELS);
    localparam logic [c_sub_bits-1:0] c_last_sub = c_sub_bits'(NUM_SUBPANELS - 1);

    fetch_state_t                         r_state;
    logic [c_cnt_bits-1:0]                r_issue_idx;
    logic [ROW_BITS-1:0]                  r_row;
    logic [COLUMN_BITS-1:0]               r_col;
    logic                                 r_inv;
    logic [NUM_SUBPANELS*PIXEL_WIDTH-1:0] r_shadow;
    logic [NUM_SUBPANELS*PIXEL_WIDTH-1:0] r_pixel;
    logic [c_addr_width-1:0]              r_addr;
    logic                                 r_done;
    logic                                 r_busy;
    logic                                 r_overrun;

    logic                    w_accept;
    logic                    w_issue;
    logic                    w_tag_in_valid;
    logic [c_sub_bits-1:0]   w_tag_in_idx;
    logic                    w_cap_valid;
    logic [c_sub_bits-1:0]   w_cap_idx;
    logic [ROW_BITS-1:0]     w_sel_row;
    logic [COLUMN_BITS-1:0]  w_sel_col;
    logic                    w_sel_inv;
    logic [31:0]             w_addr_full;
    logic [c_addr_width-1:0] w_addr;
    logic                    w_unused_addr_hi;

    assign w_accept = bus.pixel_load_start && (r_state == ST_IDLE || r_state == ST_COMMIT);
    assign w_issue  = (r_state == ST_FETCH) && (r_issue_idx < c_num_subs);

    // Sub 0 is addressed from the live inputs on the accept edge; later subs use the snapshot.
    assign w_tag_in_valid = w_accept || w_issue;
    assign w_tag_in_idx   = w_accept ? '0 : r_issue_idx[c_sub_bits-1:0];
    assign w_sel_row      = w_accept ? bus.row_address    : r_row;
    assign w_sel_col      = w_accept ? bus.column_address : r_col;
    assign w_sel_inv      = w_accept ? bus.column_invert  : r_inv;

    assign w_addr_full = fb_compose_addr(32'(w_tag_in_idx), 32'(w_sel_row), 32'(w_sel_col),
                                         w_sel_inv, ROW_BITS, COLUMN_BITS);
    assign w_addr           = w_addr_full[c_addr_width-1:0];
    assign w_unused_addr_hi = ^w_addr_full[31:c_addr_width];

    fetch_tag_pipe #(
        .LATENCY  (RAM_LATENCY),
        .IDX_BITS (c_sub_bits)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .reset   (reset),
        .i_valid (w_tag_in_valid),
        .i_idx   (w_tag_in_idx),
        .o_valid (w_cap_valid),
        .o_idx   (w_cap_idx)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_issue_idx <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_inv       <= 1'b0;
            r_shadow    <= '0;
            r_pixel     <= '0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cap_valid) begin
                r_shadow[int'(w_cap_idx)*PIXEL_WIDTH +: PIXEL_WIDTH] <= bus.ram_data_in;
            end
            if (w_tag_in_valid) begin
                r_addr <= w_addr;
            end
            if (w_accept) begin
                r_row       <= bus.row_address;
                r_col       <= bus.column_address;
                r_inv       <= bus.column_invert;
                r_issue_idx <= c_cnt_bits'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.pixel_load_start) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_issue) begin
                        r_issue_idx <= r_issue_idx + c_cnt_bits'(1);
                    end
                    if (w_cap_valid && w_cap_idx == c_last_sub) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_pixel <= r_shadow;
                    r_done  <= 1'b1;
                    r_state <= w_accept ? ST_FETCH : ST_IDLE;
                    r_busy  <= w_accept;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_address     = r_addr;
    assign bus.ram_clk_enable  = r_busy;
    assign bus.ram_reset       = ~reset;
    assign bus.pixel_data      = r_pixel;
    assign bus.pixel_load_done = r_done;
    assign bus.busy            = r_busy;
    assign bus.start_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_fetch_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_framebuffer_fetch_multi
// Brief   : Directed self-checking bench: default 2-subpanel instance plus a
//           24-bit / 4-subpanel / latency-2 instance.
// Revision: 1.0  initial release
// ============================================================================
module tb_framebuffer_fetch_multi;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt_a = 0;
    logic [23:0] ram_b_q = '0;

    always #5 clk = ~clk;

    framebuffer_fetch_multi_if #(.PIXEL_WIDTH(16), .NUM_SUBPANELS(2),
                                 .COLUMN_BITS(6), .ROW_BITS(4)) bus_a ();
    framebuffer_fetch_multi_if #(.PIXEL_WIDTH(24), .NUM_SUBPANELS(4),
                                 .COLUMN_BITS(6), .ROW_BITS(4)) bus_b ();

    framebuffer_fetch_multi #(.PIXEL_WIDTH(16), .NUM_SUBPANELS(2), .COLUMN_BITS(6),
                              .ROW_BITS(4), .RAM_LATENCY(1))
        u_dut_a (.clk_in(clk), .reset(reset), .bus(bus_a));
    framebuffer_fetch_multi #(.PIXEL_WIDTH(24), .NUM_SUBPANELS(4), .COLUMN_BITS(6),
                              .ROW_BITS(4), .RAM_LATENCY(2))
        u_dut_b (.clk_in(clk), .reset(reset), .bus(bus_b));

    function automatic logic [15:0] ram_a(input logic [10:0] a);
        return {5'b0, a} ^ 16'hA5A5;
    endfunction

    function automatic logic [23:0] ram_b(input logic [11:0] a);
        return {a, a ^ 12'hA5A};
    endfunction

    function automatic logic [10:0] addr_a(input logic sub, input logic [3:0] row,
                                           input logic [5:0] col, input logic inv);
        logic [5:0] ce;
        ce = inv ? ~col : col;
        return {sub, row, ce};
    endfunction

    function automatic logic [31:0] pix_a(input logic [3:0] row, input logic [5:0] col,
                                          input logic inv);
        return {ram_a(addr_a(1'b1, row, col, inv)), ram_a(addr_a(1'b0, row, col, inv))};
    endfunction

    // Latency 1: data is a combinational read; latency 2: one register stage.
    assign bus_a.ram_data_in = ram_a(bus_a.ram_address);
    always @(posedge clk) ram_b_q <= ram_b(bus_b.ram_address);
    assign bus_b.ram_data_in = ram_b_q;

    always @(negedge clk) if (bus_a.pixel_load_done === 1'b1) done_cnt_a++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          c0;
        logic [31:0] exp_prev;

        reset = 1'b0;
        bus_a.pixel_load_start = 1'b0; bus_a.row_address = '0;
        bus_a.column_address = '0;     bus_a.column_invert = 1'b0;
        bus_b.pixel_load_start = 1'b0; bus_b.row_address = '0;
        bus_b.column_address = '0;     bus_b.column_invert = 1'b0;
        tick(); tick();
        chk("rst_addr", bus_a.ram_address, 0);
        chk("rst_pix", bus_a.pixel_data, 0);
        chk("rst_done", bus_a.pixel_load_done, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_ovr", bus_a.start_overrun, 0);
        chk("rst_ramrst", bus_a.ram_reset, 1);
        chk("rst_clken", bus_a.ram_clk_enable, 0);
        reset = 1'b1;
        tick();
        chk("ramrst_rel", bus_a.ram_reset, 0);

        // Test 1: inverted column
        bus_a.row_address = 4'd5; bus_a.column_address = 6'd3; bus_a.column_invert = 1'b1;
        bus_a.pixel_load_start = 1'b1;
        tick();
        bus_a.pixel_load_start = 1'b0;
        chk("t1_addr0", bus_a.ram_address, 11'h17C);
        chk("t1_busy0", bus_a.busy, 1);
        chk("t1_clken", bus_a.ram_clk_enable, 1);
        tick();
        chk("t1_addr1", bus_a.ram_address, 11'h57C);
        chk("t1_busy1", bus_a.busy, 1);
        chk("t1_done1", bus_a.pixel_load_done, 0);
        tick();
        chk("t1_busy2", bus_a.busy, 1);
        chk("t1_done2", bus_a.pixel_load_done, 0);
        tick();
        chk("t1_done3", bus_a.pixel_load_done, 1);
        chk("t1_busy3", bus_a.busy, 0);
        chk("t1_pix", bus_a.pixel_data, 32'hA0D9_A4D9);
        tick();
        chk("t1_done4", bus_a.pixel_load_done, 0);
        chk("t1_hold", bus_a.pixel_data, 32'hA0D9_A4D9);

        // Test 2: input changes during the fetch are ignored
        bus_a.row_address = 4'd0; bus_a.column_address = 6'd3; bus_a.column_invert = 1'b0;
        bus_a.pixel_load_start = 1'b1;
        tick();
        bus_a.pixel_load_start = 1'b0;
        chk("t2_addr0", bus_a.ram_address, 11'h003);
        bus_a.row_address = 4'($urandom); bus_a.column_address = 6'($urandom);
        tick();
        chk("t2_addr1", bus_a.ram_address, 11'h403);
        bus_a.row_address = 4'($urandom); bus_a.column_address = 6'($urandom);
        bus_a.column_invert = 1'b1;
        tick(); tick();
        chk("t2_done", bus_a.pixel_load_done, 1);
        chk("t2_pix", bus_a.pixel_data, 32'hA1A6_A5A6);

        // Test 3: start held through FETCH, chained restart at COMMIT
        bus_a.row_address = 4'd2; bus_a.column_address = 6'd10; bus_a.column_invert = 1'b0;
        bus_a.pixel_load_start = 1'b1;
        tick();
        chk("t3_addr0", bus_a.ram_address, 11'h08A);
        chk("t3_ovr0", bus_a.start_overrun, 0);
        tick();
        chk("t3_ovr1", bus_a.start_overrun, 1);
        chk("t3_addr1", bus_a.ram_address, 11'h48A);
        tick();
        bus_a.row_address = 4'd7; bus_a.column_address = 6'd1; bus_a.column_invert = 1'b1;
        tick();
        bus_a.pixel_load_start = 1'b0;
        chk("t3_done_a", bus_a.pixel_load_done, 1);
        chk("t3_pix_a", bus_a.pixel_data, 32'hA12F_A52F);
        chk("t3_chain_addr", bus_a.ram_address, 11'h1FE);
        chk("t3_chain_busy", bus_a.busy, 1);
        tick();
        chk("t3_gap1", bus_a.pixel_load_done, 0);
        tick();
        chk("t3_gap2", bus_a.pixel_load_done, 0);
        tick();
        chk("t3_done_b", bus_a.pixel_load_done, 1);
        chk("t3_pix_b", bus_a.pixel_data, 32'hA05B_A45B);
        chk("t3_ovr_sticky", bus_a.start_overrun, 1);

        // Test 4: reset in the middle of a fetch
        bus_a.row_address = 4'd1; bus_a.column_address = 6'd1; bus_a.column_invert = 1'b0;
        bus_a.pixel_load_start = 1'b1;
        tick();
        bus_a.pixel_load_start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t4_done", bus_a.pixel_load_done, 0);
        chk("t4_pix", bus_a.pixel_data, 0);
        chk("t4_busy", bus_a.busy, 0);
        chk("t4_ovr", bus_a.start_overrun, 0);
        chk("t4_addr", bus_a.ram_address, 0);
        c0 = done_cnt_a;
        tick(); tick(); tick();
        chk("t4_no_done", done_cnt_a - c0, 0);
        bus_a.row_address = 4'd3; bus_a.column_address = 6'h20;
        bus_a.pixel_load_start = 1'b1;
        tick();
        bus_a.pixel_load_start = 1'b0;
        chk("t4_addr0", bus_a.ram_address, 11'h0E0);
        tick(); tick(); tick();
        chk("t4_done2", bus_a.pixel_load_done, 1);
        chk("t4_pix2", bus_a.pixel_data, 32'hA145_A545);

        // Test 5: 24-bit, four subpanels, RAM latency 2
        bus_b.row_address = 4'd9; bus_b.column_address = 6'h15; bus_b.column_invert = 1'b1;
        bus_b.pixel_load_start = 1'b1;
        tick();
        bus_b.pixel_load_start = 1'b0;
        chk("t5_addr0", bus_b.ram_address, 12'h26A);
        tick();
        chk("t5_addr1", bus_b.ram_address, 12'h66A);
        tick();
        chk("t5_addr2", bus_b.ram_address, 12'hA6A);
        tick();
        chk("t5_addr3", bus_b.ram_address, 12'hE6A);
        tick();
        chk("t5_hold4", bus_b.ram_address, 12'hE6A);
        tick();
        chk("t5_done5", bus_b.pixel_load_done, 0);
        chk("t5_busy5", bus_b.busy, 1);
        tick();
        chk("t5_done6", bus_b.pixel_load_done, 1);
        chk("t5_pix", bus_b.pixel_data, 96'hE6A430_A6A030_66AC30_26A830);
        tick();
        chk("t5_done7", bus_b.pixel_load_done, 0);

        // Test 6: back-to-back starts at the minimum period across 64 columns
        c0 = done_cnt_a;
        exp_prev = '0;
        for (int i = 0; i < 64; i++) begin
            bus_a.row_address    = 4'(i);
            bus_a.column_address = 6'(i);
            bus_a.column_invert  = i[0];
            bus_a.pixel_load_start = 1'b1;
            tick();
            if (i > 0) begin
                chk("t6_done", bus_a.pixel_load_done, 1);
                chk("t6_pix", bus_a.pixel_data, exp_prev);
            end
            exp_prev = pix_a(4'(i), 6'(i), i[0]);
            bus_a.pixel_load_start = 1'b0;
            tick(); tick();
        end
        tick();
        chk("t6_last_done", bus_a.pixel_load_done, 1);
        chk("t6_last_pix", bus_a.pixel_data, exp_prev);
        tick();
        chk("t6_count", done_cnt_a - c0, 64);
        chk("t6_ovr", bus_a.start_overrun, 0);
        chk("t6_idle", bus_a.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/framebuffer_fetch_multi.md
Name: framebuffer_fetch_multi

Overview:
Parametrised successor to the single-port top/bottom pixel fetcher. It sits between the scan controller and the framebuffer BRAM. It fetches one pixel per subpanel (NUM_SUBPANELS halves/quarters of the panel) for a given row/column and tolerates a configurable RAM read latency. All subpanel pixels are presented atomically on one output bus with a done pulse. Added over the previous generation: generic width/depth/subpanel count, pipelined issue/capture, runtime column mirroring, atomic commit, back-to-back starts and overrun detection.

Parameters:
PIXEL_WIDTH, 16, bits per pixel word from RAM (16 = RGB565, 24 = RGB888).
NUM_SUBPANELS, 2, pixels fetched per start; power of two, at least 2.
COLUMN_BITS, 6, column address width.
ROW_BITS, 4, row address width.
RAM_LATENCY, 1, clock edges from ram_address change to valid ram_data_in; range 1..3.
Derived (localparam): SUB_BITS = clog2(NUM_SUBPANELS); ADDR_WIDTH = SUB_BITS + ROW_BITS + COLUMN_BITS.

Ports:
clk_in  input  1  single clock; all logic is on the posedge.
reset  input  1  synchronous, active-low; reset==0 at a posedge resets the block.
column_address  input  COLUMN_BITS  column to fetch; sampled on start acceptance.
row_address  input  ROW_BITS  row to fetch; sampled on start acceptance.
column_invert  input  1  1 = use ~column_address (mirrored panel); sampled on start acceptance.
pixel_load_start  input  1  fetch request, level-sampled at each posedge.
ram_data_in  input  PIXEL_WIDTH  RAM read data.
ram_address  output  ADDR_WIDTH  registered address {sub_idx, row, col_eff}.
ram_clk_enable  output  1  high while state != IDLE.
ram_reset  output  1  active-high RAM reset = ~reset (combinational).
pixel_data  output  NUM_SUBPANELS*PIXEL_WIDTH  subpanel k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH].
pixel_load_done  output  1  one-cycle pulse when pixel_data updates.
busy  output  1  registered, state != IDLE.
start_overrun  output  1  sticky; set when a start is ignored.

Behaviour:
- Reset values: ram_address 0, pixel_data 0, shadow 0, pixel_load_done 0, busy 0, start_overrun 0, state IDLE, all counters and tag pipeline 0.
- States: IDLE, FETCH, COMMIT.
- Edge 0: start is accepted in IDLE or COMMIT. Row, column and invert go into snapshot registers. ram_address <= sub 0 address. Issue index = 1. State -> FETCH.
- FETCH, edges 1..NUM_SUBPANELS-1: ram_address <= address of the sub indicated by the issue index; the index then increments. After the last issue, ram_address holds its value.
- Capture: sub k's word is sampled into shadow slot k at edge k+RAM_LATENCY. A valid/index tag pipeline of depth RAM_LATENCY drives this.
- Edge NUM_SUBPANELS-1+RAM_LATENCY: last capture; state -> COMMIT.
- Edge NUM_SUBPANELS+RAM_LATENCY: pixel_data <= shadow, with all slots updated together. pixel_load_done = 1 for exactly one cycle. State -> IDLE, or -> FETCH if start is asserted (chained request).
- Latency from accepted start to done is NUM_SUBPANELS+RAM_LATENCY edges. Minimum start period is the same value.
- Start seen in FETCH: ignored, start_overrun <= 1, and it stays set until reset. The in-flight fetch is unaffected.
- Input address/invert changes during FETCH/COMMIT have no effect on the in-flight fetch.
- Reset mid-operation: everything returns to reset values at that edge. No done pulse. pixel_data is cleared.
- Address arithmetic: col_eff = column_invert ? ~column : column, width COLUMN_BITS. sub_idx is zero-extended to SUB_BITS. No overflow is possible.
- pixel_data holds its value between commits.

Decomposition:
- Shared package/header framebuffer_fetch_pkg holds:
  - state encoding localparams (IDLE/FETCH/COMMIT);
  - the address compose function (sub, row, col, invert -> address);
  - the SUB_BITS/ADDR_WIDTH derivation.
- One sub-module, fetch_tag_pipe: a parametrised RAM_LATENCY-deep shift register carrying {valid, sub_idx}. It has synchronous active-low reset.

Test Plan:
1. Defaults, row=5, col=3, invert=1, RAM model data = address ^ 16'hA5A5, one start pulse -> ram_address 0x17C then 0x57C. pixel_data = {0x57C^A5A5, 0x17C^A5A5}. Done pulses at edge 3. busy is high for 3 cycles.
2. Defaults, invert=0, col=3, row=0 -> addresses 0x003 and 0x403. Changing row/col to random values at edges 1..2 alters neither the addresses nor the data.
3. Start held high across FETCH -> start_overrun=1 after edge 1. The first result is correct. Chained restart is accepted at COMMIT, giving a second done pulse exactly 3 edges after the first.
4. reset=0 at edge 2 of a fetch -> no done pulse. pixel_data=0, busy=0, start_overrun=0 next cycle. A new start afterwards completes normally.
5. PIXEL_WIDTH=24, NUM_SUBPANELS=4, RAM_LATENCY=2 -> sub indices 0..3 issued on edges 0..3, done at edge 6. Each 24-bit slot k matches the model data for sub k.
6. Continuous starts every NUM_SUBPANELS+RAM_LATENCY cycles over 64 columns -> 64 done pulses, no overrun, every result matches the model.
